// File: rtl/fifo_rd_packer.sv
// Read-domain packer: pops narrow words from the async FIFO read port and packs them into wide output words.
// Optional RD_POPCNT_EN adds free-running pop_count / word_count statistics outputs.
module fifo_rd_packer #(
  parameter int unsigned datawidth = 8,
  parameter int unsigned ratio     = 4
) (
  input  logic                           rclk,
  input  logic                           rrst_n,
  input  logic [datawidth-1:0]           rdata,
  input  logic                           rempty,
  output logic                           rinc,
  output logic [ratio*datawidth-1:0]     m_data,
  output logic [ratio-1:0]               m_keep,
  output logic                           m_last,
  output logic                           m_valid,
  input  logic                           m_ready,
  input  logic                           flush,
  output logic                           flush_done,
  output logic                           busy
`ifdef RD_POPCNT_EN
  ,output logic [15:0]                   pop_count
  ,output logic [15:0]                   word_count
`endif
);

  localparam int unsigned IDX_W = (ratio > 1) ? $clog2(ratio) : 1;
  localparam int unsigned OUT_W = ratio * datawidth;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(ratio - 1);

  localparam logic [0:0] ST_FILL  = 1'b0;
  localparam logic [0:0] ST_FLUSH = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [OUT_W-1:0] acc_q, acc_d;
  logic [1:0]       ocnt_q, ocnt_d;
  logic [OUT_W-1:0] hd_data_q, hd_data_d, tl_data_q, tl_data_d;
  logic [ratio-1:0] hd_keep_q, hd_keep_d, tl_keep_q, tl_keep_d;
  logic             hd_last_q, hd_last_d, tl_last_q, tl_last_d;
  logic             flush_done_q, flush_done_d;
  logic             busy_q, busy_d;
  logic             m_valid_q, m_valid_d;

  logic             rinc_c;
  logic             space_c;
  logic             out_pop_c;
  logic             push_c;
  logic [OUT_W-1:0] push_data_c;
  logic [ratio-1:0] push_keep_c;
  logic             push_last_c;
  logic [ratio-1:0] keep_mask_c;

  // Lanes below the current index hold valid data during a partial flush.
  always_comb begin
    keep_mask_c = '0;
    for (int i = 0; i < int'(ratio); i++) begin
      keep_mask_c[i] = (i < int'(idx_q));
    end
  end

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    acc_d        = acc_q;
    ocnt_d       = ocnt_q;
    hd_data_d    = hd_data_q;
    hd_keep_d    = hd_keep_q;
    hd_last_d    = hd_last_q;
    tl_data_d    = tl_data_q;
    tl_keep_d    = tl_keep_q;
    tl_last_d    = tl_last_q;
    flush_done_d = 1'b0;
    push_c       = 1'b0;
    push_data_c  = '0;
    push_keep_c  = '0;
    push_last_c  = 1'b0;

    out_pop_c = m_valid_q & m_ready;
    space_c   = (ocnt_q < 2'd2) | out_pop_c;
    // Last lane may only be popped when the completed word has somewhere to go.
    rinc_c    = rrst_n & (state_q == ST_FILL) & ~flush & ~rempty &
                ((idx_q != IDX_LAST) | space_c);

    case (state_q)
      ST_FILL: begin
        if (flush) begin
          state_d = ST_FLUSH;
        end else if (rinc_c) begin
          acc_d[idx_q*datawidth +: datawidth] = rdata;
          if (idx_q == IDX_LAST) begin
            push_c      = 1'b1;
            push_data_c = acc_d;
            push_keep_c = '1;
            idx_d       = '0;
            acc_d       = '0;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      ST_FLUSH: begin
        if (space_c) begin
          if (idx_q != '0) begin
            push_c      = 1'b1;
            push_data_c = acc_q;
            push_keep_c = keep_mask_c;
            push_last_c = 1'b1;
          end
          idx_d        = '0;
          acc_d        = '0;
          flush_done_d = 1'b1;
          state_d      = ST_FILL;
        end
      end
      default: state_d = ST_FILL;
    endcase

    // Two-entry output buffer: head drives the stream, tail catches the overflow word.
    case ({push_c, out_pop_c})
      2'b10: begin
        if (ocnt_q == 2'd0) begin
          hd_data_d = push_data_c;
          hd_keep_d = push_keep_c;
          hd_last_d = push_last_c;
        end else begin
          tl_data_d = push_data_c;
          tl_keep_d = push_keep_c;
          tl_last_d = push_last_c;
        end
        ocnt_d = ocnt_q + 2'd1;
      end
      2'b01: begin
        hd_data_d = tl_data_q;
        hd_keep_d = tl_keep_q;
        hd_last_d = tl_last_q;
        ocnt_d    = ocnt_q - 2'd1;
      end
      2'b11: begin
        if (ocnt_q == 2'd1) begin
          hd_data_d = push_data_c;
          hd_keep_d = push_keep_c;
          hd_last_d = push_last_c;
        end else begin
          hd_data_d = tl_data_q;
          hd_keep_d = tl_keep_q;
          hd_last_d = tl_last_q;
          tl_data_d = push_data_c;
          tl_keep_d = push_keep_c;
          tl_last_d = push_last_c;
        end
      end
      default: ;
    endcase

    m_valid_d = (ocnt_d != 2'd0);
    busy_d    = (idx_d != '0) | (state_d == ST_FLUSH);
  end

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      state_q      <= ST_FILL;
      idx_q        <= '0;
      acc_q        <= '0;
      ocnt_q       <= '0;
      hd_data_q    <= '0;
      hd_keep_q    <= '0;
      hd_last_q    <= 1'b0;
      tl_data_q    <= '0;
      tl_keep_q    <= '0;
      tl_last_q    <= 1'b0;
      flush_done_q <= 1'b0;
      busy_q       <= 1'b0;
      m_valid_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      acc_q        <= acc_d;
      ocnt_q       <= ocnt_d;
      hd_data_q    <= hd_data_d;
      hd_keep_q    <= hd_keep_d;
      hd_last_q    <= hd_last_d;
      tl_data_q    <= tl_data_d;
      tl_keep_q    <= tl_keep_d;
      tl_last_q    <= tl_last_d;
      flush_done_q <= flush_done_d;
      busy_q       <= busy_d;
      m_valid_q    <= m_valid_d;
    end
  end

  assign rinc       = rinc_c;
  assign m_data     = hd_data_q;
  assign m_keep     = hd_keep_q;
  assign m_last     = hd_last_q;
  assign m_valid    = m_valid_q;
  assign flush_done = flush_done_q;
  assign busy       = busy_q;

`ifdef RD_POPCNT_EN
  logic [15:0] pop_cnt_q, word_cnt_q;

  // Free-running statistics; both wrap naturally at 16 bits.
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      pop_cnt_q  <= '0;
      word_cnt_q <= '0;
    end else begin
      if (rinc_c)    pop_cnt_q  <= pop_cnt_q + 16'd1;
      if (out_pop_c) word_cnt_q <= word_cnt_q + 16'd1;
    end
  end

  assign pop_count  = pop_cnt_q;
  assign word_count = word_cnt_q;
`endif

endmodule

// File: tb/tb_fifo_rd_packer.sv
// Directed self-checking bench for fifo_rd_packer (datawidth=8, ratio=4) with a queue-based FIFO model.
module tb_fifo_rd_packer;

  localparam int unsigned DW    = 8;
  localparam int unsigned RATIO = 4;
  localparam int unsigned OW    = DW * RATIO;

  logic             rclk = 1'b0;
  logic             rrst_n;
  logic [DW-1:0]    rdata;
  logic             rempty;
  logic             rinc;
  logic [OW-1:0]    m_data;
  logic [RATIO-1:0] m_keep;
  logic             m_last;
  logic             m_valid;
  logic             m_ready;
  logic             flush;
  logic             flush_done;
  logic             busy;
`ifdef RD_POPCNT_EN
  logic [15:0]      pop_count;
  logic [15:0]      word_count;
`endif

  fifo_rd_packer #(.datawidth(DW), .ratio(RATIO)) dut (
    .rclk       (rclk),
    .rrst_n     (rrst_n),
    .rdata      (rdata),
    .rempty     (rempty),
    .rinc       (rinc),
    .m_data     (m_data),
    .m_keep     (m_keep),
    .m_last     (m_last),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .flush      (flush),
    .flush_done (flush_done),
    .busy       (busy)
`ifdef RD_POPCNT_EN
    ,.pop_count (pop_count)
    ,.word_count(word_count)
`endif
  );

  always #5 rclk = ~rclk;

  int total = 0;
  int bad   = 0;

  logic [DW-1:0]    fifo_q[$];
  logic [OW-1:0]    rx_data[$];
  logic [RATIO-1:0] rx_keep[$];
  logic             rx_last[$];
  int               cyc = 0;
  int               pops = 0;
  int               fd_cnt = 0;
  int               empty_viol = 0;
  int               first_valid_cyc = -1;
  int               pop4_cyc = -1;

  task automatic refresh();
    rempty = (fifo_q.size() == 0);
    rdata  = rempty ? '0 : fifo_q[0];
  endtask

  task automatic push_word(input logic [DW-1:0] w);
    fifo_q.push_back(w);
    refresh();
  endtask

  task automatic clear_rx();
    rx_data.delete();
    rx_keep.delete();
    rx_last.delete();
  endtask

  // One clock: observe at the falling edge, then retire any FIFO pop after the rising edge.
  task automatic tick();
    logic pop_now;
    int   c;
    @(negedge rclk);
    c       = cyc;
    pop_now = rinc;
    if (rinc && rempty) empty_viol++;
    if (flush_done) fd_cnt++;
    if (m_valid && first_valid_cyc < 0) first_valid_cyc = c;
    if (m_valid && m_ready) begin
      rx_data.push_back(m_data);
      rx_keep.push_back(m_keep);
      rx_last.push_back(m_last);
    end
    @(posedge rclk);
    #1;
    cyc++;
    if (pop_now) begin
      if (pops == 3) pop4_cyc = c;
      pops++;
      if (fifo_q.size() > 0) void'(fifo_q.pop_front());
    end
    refresh();
  endtask

  task automatic test_reset();
    rrst_n  = 1'b0;
    m_ready = 1'b0;
    flush   = 1'b0;
    refresh();
    #2;
    total++; if (m_valid !== 1'b0)   begin bad++; $display("FAIL reset_m_valid got=%0b exp=0", m_valid); end
    total++; if (m_data !== '0)      begin bad++; $display("FAIL reset_m_data got=%h exp=0", m_data); end
    total++; if (m_keep !== '0)      begin bad++; $display("FAIL reset_m_keep got=%h exp=0", m_keep); end
    total++; if (m_last !== 1'b0)    begin bad++; $display("FAIL reset_m_last got=%0b exp=0", m_last); end
    total++; if (flush_done !== 1'b0) begin bad++; $display("FAIL reset_flush_done got=%0b exp=0", flush_done); end
    total++; if (busy !== 1'b0)      begin bad++; $display("FAIL reset_busy got=%0b exp=0", busy); end
    total++; if (rinc !== 1'b0)      begin bad++; $display("FAIL reset_rinc got=%0b exp=0", rinc); end
    tick();
    tick();
    rrst_n = 1'b1;
    tick();
  endtask

  task automatic test_stream();
    clear_rx();
    pops    = 0;
    m_ready = 1'b1;
    for (int i = 1; i <= 8; i++) push_word(8'(i));
    repeat (14) tick();
    total++; if (pops !== 8) begin bad++; $display("FAIL stream_pops got=%0d exp=8", pops); end
    total++; if (rx_data.size() !== 2) begin bad++; $display("FAIL stream_count got=%0d exp=2", rx_data.size()); end
    if (rx_data.size() >= 2) begin
      total++; if (rx_data[0] !== 32'h04030201) begin bad++; $display("FAIL stream_w0 got=%h exp=04030201", rx_data[0]); end
      total++; if (rx_keep[0] !== 4'hF || rx_last[0] !== 1'b0) begin bad++; $display("FAIL stream_w0_keeplast got=%h/%0b exp=f/0", rx_keep[0], rx_last[0]); end
      total++; if (rx_data[1] !== 32'h08070605) begin bad++; $display("FAIL stream_w1 got=%h exp=08070605", rx_data[1]); end
      total++; if (rx_keep[1] !== 4'hF || rx_last[1] !== 1'b0) begin bad++; $display("FAIL stream_w1_keeplast got=%h/%0b exp=f/0", rx_keep[1], rx_last[1]); end
    end
    total++; if (busy !== 1'b0 || m_valid !== 1'b0) begin bad++; $display("FAIL stream_idle busy=%0b valid=%0b exp=0/0", busy, m_valid); end
`ifdef RD_POPCNT_EN
    total++; if (pop_count !== 16'd8)  begin bad++; $display("FAIL stream_pop_count got=%0d exp=8", pop_count); end
    total++; if (word_count !== 16'd2) begin bad++; $display("FAIL stream_word_count got=%0d exp=2", word_count); end
`endif
  endtask

  task automatic test_backpressure();
    clear_rx();
    pops    = 0;
    m_ready = 1'b0;
    for (int i = 0; i < 12; i++) push_word(8'(8'h21 + i));
    repeat (16) tick();
    // Two full words buffered plus three lanes accumulated; the last lane is held back.
    total++; if (pops !== 11) begin bad++; $display("FAIL bp_pops got=%0d exp=11", pops); end
    total++; if (rinc !== 1'b0 || rempty !== 1'b0) begin bad++; $display("FAIL bp_rinc_held rinc=%0b rempty=%0b exp=0/0", rinc, rempty); end
    total++; if (m_valid !== 1'b1 || busy !== 1'b1) begin bad++; $display("FAIL bp_status valid=%0b busy=%0b exp=1/1", m_valid, busy); end
    total++; if (m_data !== 32'h24232221 || m_keep !== 4'hF) begin bad++; $display("FAIL bp_head_stable got=%h/%h exp=24232221/f", m_data, m_keep); end
    m_ready = 1'b1;
    repeat (10) tick();
    total++; if (pops !== 12) begin bad++; $display("FAIL bp_drain_pops got=%0d exp=12", pops); end
    total++; if (rx_data.size() !== 3) begin bad++; $display("FAIL bp_drain_count got=%0d exp=3", rx_data.size()); end
    if (rx_data.size() >= 3) begin
      total++; if (rx_data[0] !== 32'h24232221) begin bad++; $display("FAIL bp_w0 got=%h exp=24232221", rx_data[0]); end
      total++; if (rx_data[1] !== 32'h28272625) begin bad++; $display("FAIL bp_w1 got=%h exp=28272625", rx_data[1]); end
      total++; if (rx_data[2] !== 32'h2C2B2A29) begin bad++; $display("FAIL bp_w2 got=%h exp=2c2b2a29", rx_data[2]); end
    end
  endtask

  task automatic test_flush_partial();
    clear_rx();
    pops    = 0;
    fd_cnt  = 0;
    m_ready = 1'b1;
    push_word(8'hAA);
    push_word(8'hBB);
    repeat (3) tick();
    total++; if (pops !== 2 || busy !== 1'b1) begin bad++; $display("FAIL fp_partial pops=%0d busy=%0b exp=2/1", pops, busy); end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL fp_busy_in_flush got=%0b exp=1", busy); end
    repeat (4) tick();
    total++; if (rx_data.size() !== 1) begin bad++; $display("FAIL fp_count got=%0d exp=1", rx_data.size()); end
    if (rx_data.size() >= 1) begin
      total++; if (rx_data[0] !== 32'h0000BBAA) begin bad++; $display("FAIL fp_data got=%h exp=0000bbaa", rx_data[0]); end
      total++; if (rx_keep[0] !== 4'h3 || rx_last[0] !== 1'b1) begin bad++; $display("FAIL fp_keeplast got=%h/%0b exp=3/1", rx_keep[0], rx_last[0]); end
    end
    total++; if (fd_cnt !== 1) begin bad++; $display("FAIL fp_flush_done got=%0d exp=1", fd_cnt); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL fp_busy_after got=%0b exp=0", busy); end
  endtask

  task automatic test_flush_empty();
    clear_rx();
    pops   = 0;
    fd_cnt = 0;
    flush  = 1'b1;
    tick();
    flush  = 1'b0;
    repeat (4) tick();
    total++; if (fd_cnt !== 1) begin bad++; $display("FAIL fe_flush_done got=%0d exp=1", fd_cnt); end
    total++; if (rx_data.size() !== 0 || m_valid !== 1'b0) begin bad++; $display("FAIL fe_no_output count=%0d valid=%0b exp=0/0", rx_data.size(), m_valid); end
    total++; if (pops !== 0) begin bad++; $display("FAIL fe_pops got=%0d exp=0", pops); end
  endtask

  task automatic test_empty_hold();
    clear_rx();
    pops       = 0;
    empty_viol = 0;
    m_ready    = 1'b1;
    repeat (20) tick();
    total++; if (pops !== 0) begin bad++; $display("FAIL eh_no_pop got=%0d exp=0", pops); end
    first_valid_cyc = -1;
    pop4_cyc        = -1;
    for (int i = 0; i < 4; i++) push_word(8'(8'h31 + i));
    repeat (8) tick();
    total++; if (empty_viol !== 0) begin bad++; $display("FAIL eh_rinc_while_empty got=%0d exp=0", empty_viol); end
    total++; if (pop4_cyc < 0 || first_valid_cyc !== pop4_cyc + 1) begin bad++; $display("FAIL eh_latency valid_cyc=%0d exp=%0d", first_valid_cyc, pop4_cyc + 1); end
    total++; if (rx_data.size() !== 1 || (rx_data.size() == 1 && rx_data[0] !== 32'h34333231)) begin bad++; $display("FAIL eh_data count=%0d exp 1 word 34333231", rx_data.size()); end
  endtask

  task automatic test_reset_mid();
    clear_rx();
    m_ready = 1'b0;
    for (int i = 0; i < 6; i++) push_word(8'(8'h41 + i));
    repeat (8) tick();
    total++; if (m_valid !== 1'b1 || busy !== 1'b1) begin bad++; $display("FAIL rm_pre valid=%0b busy=%0b exp=1/1", m_valid, busy); end
    #2;
    rrst_n = 1'b0;
    #1;
    total++; if (m_valid !== 1'b0 || m_data !== '0) begin bad++; $display("FAIL rm_async_data valid=%0b data=%h exp=0/0", m_valid, m_data); end
    total++; if (m_keep !== '0 || m_last !== 1'b0) begin bad++; $display("FAIL rm_async_keeplast got=%h/%0b exp=0/0", m_keep, m_last); end
    total++; if (busy !== 1'b0 || flush_done !== 1'b0 || rinc !== 1'b0) begin bad++; $display("FAIL rm_async_ctrl busy=%0b fd=%0b rinc=%0b exp=0/0/0", busy, flush_done, rinc); end
    tick();
    tick();
    rrst_n  = 1'b1;
    m_ready = 1'b1;
    clear_rx();
    for (int i = 0; i < 4; i++) push_word(8'(8'h11 + i));
    repeat (8) tick();
    total++; if (rx_data.size() !== 1) begin bad++; $display("FAIL rm_count got=%0d exp=1", rx_data.size()); end
    if (rx_data.size() >= 1) begin
      total++; if (rx_data[0] !== 32'h14131211) begin bad++; $display("FAIL rm_data got=%h exp=14131211", rx_data[0]); end
      total++; if (rx_keep[0] !== 4'hF || rx_last[0] !== 1'b0) begin bad++; $display("FAIL rm_keeplast got=%h/%0b exp=f/0", rx_keep[0], rx_last[0]); end
    end
`ifdef RD_POPCNT_EN
    total++; if (pop_count !== 16'd4 || word_count !== 16'd1) begin bad++; $display("FAIL rm_counters got=%0d/%0d exp=4/1", pop_count, word_count); end
`endif
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_flush_partial();
    test_flush_empty();
    test_empty_hold();
    test_reset_mid();
    total++; if (empty_viol !== 0) begin bad++; $display("FAIL global_rinc_while_empty got=%0d exp=0", empty_viol); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
